// File: rtl/decode_stage_pkg.sv
// RV32I opcode constants, decode enums and the decoded bundle type
// shared by the decode stage and anything that re-decodes instructions.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef logic [4:0] reg_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [3:0] {
        CLS_ALU_RR  = 4'd0,
        CLS_ALU_IMM = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9
    } instr_class_t;

    typedef struct packed {
        reg_t         rs1;
        reg_t         rs2;
        reg_t         rd;
        alu_op_t      alu;
        instr_class_t cls;
        logic [2:0]   f3;
        logic         reg_we;
        logic         use_rs1;
        logic         use_rs2;
        logic         ecall;
        logic         ebreak;
        logic         illegal;
    } dec_t;

    // alt selects SUB over ADD and SRA over SRL
    function automatic alu_op_t alu_of(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decode of one instruction word into a
// control bundle and sign-extended immediate.
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output dec_t            o_dec,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0]  w_opc;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm;
    logic        w_ill;
    logic        w_wr;
    dec_t        w_dec;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        w_dec         = '0;
        w_dec.rs1     = i_instr[19:15];
        w_dec.rs2     = i_instr[24:20];
        w_dec.rd      = i_instr[11:7];
        w_dec.f3      = w_f3;
        w_dec.alu     = ALU_ADD;
        w_dec.cls     = CLS_ALU_RR;
        w_dec.use_rs1 = 1'b1;
        w_imm         = '0;
        w_ill         = 1'b0;
        w_wr          = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_dec.use_rs2 = 1'b1;
                w_wr          = 1'b1;
                w_dec.alu     = alu_of(w_f3, w_f7 == F7_ALT);
                w_ill = !(w_f7 == F7_BASE ||
                          (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                w_dec.cls = CLS_ALU_IMM;
                w_wr      = 1'b1;
                w_imm     = w_imm_i;
                w_dec.alu = alu_of(w_f3, w_f3 == 3'b101 && i_instr[30]);
                w_ill = (w_f3 == 3'b001 && w_f7 != F7_BASE) ||
                        (w_f3 == 3'b101 && w_f7 != F7_BASE && w_f7 != F7_ALT);
            end
            OPC_LOAD: begin
                w_dec.cls = CLS_LOAD;
                w_wr      = 1'b1;
                w_imm     = w_imm_i;
                w_ill     = w_f3 == 3'b011 || w_f3[2:1] == 2'b11;
            end
            OPC_STORE: begin
                w_dec.cls     = CLS_STORE;
                w_dec.use_rs2 = 1'b1;
                w_imm         = w_imm_s;
                w_ill         = w_f3[2] || w_f3 == 3'b011;
            end
            OPC_BRANCH: begin
                w_dec.cls     = CLS_BRANCH;
                w_dec.alu     = ALU_SUB;
                w_dec.use_rs2 = 1'b1;
                w_imm         = w_imm_b;
                w_ill         = w_f3[2:1] == 2'b01;
            end
            OPC_JAL: begin
                w_dec.cls     = CLS_JAL;
                w_dec.use_rs1 = 1'b0;
                w_wr          = 1'b1;
                w_imm         = w_imm_j;
            end
            OPC_JALR: begin
                w_dec.cls = CLS_JALR;
                w_wr      = 1'b1;
                w_imm     = w_imm_i;
                w_ill     = w_f3 != 3'b000;
            end
            OPC_LUI: begin
                w_dec.cls     = CLS_LUI;
                w_dec.rs1     = '0;
                w_dec.use_rs1 = 1'b0;
                w_wr          = 1'b1;
                w_imm         = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec.cls     = CLS_AUIPC;
                w_dec.use_rs1 = 1'b0;
                w_wr          = 1'b1;
                w_imm         = w_imm_u;
            end
            OPC_SYSTEM: begin
                w_dec.cls     = CLS_SYSTEM;
                w_dec.use_rs1 = 1'b0;
                w_dec.ecall   = i_instr == INSTR_ECALL;
                w_dec.ebreak  = i_instr == INSTR_EBREAK;
                w_ill         = !(w_dec.ecall || w_dec.ebreak);
            end
            default: begin
                w_dec.use_rs1 = 1'b0;
                w_ill         = 1'b1;
            end
        endcase
        w_dec.illegal = w_ill;
        w_dec.reg_we  = w_wr && !w_ill && (w_dec.rd != '0);
    end

    assign o_dec = w_dec;
    assign o_imm = XLEN'($signed(w_imm));

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decode_comb behind a single-entry output
// register with valid/ready on both sides and a redirect flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic [3:0]      out_cls,
    output logic [2:0]      out_f3,
    output logic            out_reg_we,
    output logic            out_use_rs1,
    output logic            out_use_rs2,
    output logic            out_ecall,
    output logic            out_ebreak,
    output logic            out_illegal
);

    dec_t            w_dec;
    logic [XLEN-1:0] w_imm;
    logic            w_load;

    logic            r_valid;
    dec_t            r_dec;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;

    decode_comb #(
        .XLEN (XLEN)
    ) u_dec (
        .i_instr (in_instr),
        .o_dec   (w_dec),
        .o_imm   (w_imm)
    );

    assign in_ready = !r_valid || out_ready;
    // A flush squashes the instruction offered in the same cycle
    assign w_load   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (w_load)
                r_valid <= 1'b1;
            else if (out_ready)
                r_valid <= 1'b0;
            if (w_load) begin
                r_dec <= w_dec;
                r_imm <= w_imm;
                r_pc  <= in_pc;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_imm     = r_imm;
    assign out_rs1     = r_dec.rs1;
    assign out_rs2     = r_dec.rs2;
    assign out_rd      = r_dec.rd;
    assign out_alu_op  = r_dec.alu;
    assign out_cls     = r_dec.cls;
    assign out_f3      = r_dec.f3;
    assign out_reg_we  = r_dec.reg_we;
    assign out_use_rs1 = r_dec.use_rs1;
    assign out_use_rs2 = r_dec.use_rs2;
    assign out_ecall   = r_dec.ecall;
    assign out_ebreak  = r_dec.ebreak;
    assign out_illegal = r_dec.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32I instruction decoder. It takes fetched instruction words plus their PC and emits decoded control fields, register indices and a sign-extended immediate.
- Sits between the fetch stage and the register-read/execute stage of the core.
- Single-entry output register with a valid/ready handshake on both sides and a flush input for redirects.
- Hardware counterpart of the instruction-generation functions in the shared riscv package: it decodes what those functions encode.

Parameters:
- XLEN, 32, datapath width for imm, pc and instruction.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  PC of in_instr.
- flush  input  1  squash held and incoming instruction.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts bundle.
- out_pc  output  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  output  5 each  register indices (reg_t).
- out_imm  output  XLEN  sign-extended immediate.
- out_alu_op  output  4  alu_op_t.
- out_cls  output  4  instr_class_t: ALU_RR, ALU_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM.
- out_f3  output  3  raw funct3 (branch condition / mem size+sign).
- out_reg_we  output  1  writes rd.
- out_use_rs1, out_use_rs2  output  1 each  source operand is read (for hazard logic).
- out_ecall, out_ebreak  output  1 each  system instruction flags.
- out_illegal  output  1  illegal encoding.

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all payload outputs are 0.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
  - The register loads when in_valid && in_ready.
  - Latency is exactly 1 cycle, so full throughput is 1 instruction per cycle under continuous out_ready.
- Holding and dropping:
  - If out_valid && !out_ready, payload and out_valid are held stable.
  - If out_ready && !(in_valid && in_ready), out_valid clears next cycle.
- Flush: out_valid=0 next cycle, and any in_valid in the same cycle is dropped (flush wins). Payload need not clear.
- Immediates, selected by opcode:
  - I: sext(i[31:20]).
  - S: sext({i[31:25],i[11:7]}).
  - B: sext({i[31],i[7],i[30:25],i[11:8],1'b0}).
  - U: {i[31:12],12'b0}.
  - J: sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
  - RR and SYSTEM: 0.
- ALU op:
  - RR uses funct3 with funct7 bit 30 selecting SUB/SRA.
  - I_OP uses funct3, with SRAI when i[30]=1 and f3=101. out_imm[4:0] is the shamt.
  - LOAD, STORE, JAL, JALR and AUIPC use ADD.
  - BRANCH uses SUB.
  - LUI uses ADD with rs1 forced to x0.
- reg_we = 1 for ALU_RR, ALU_IMM, LOAD, JAL, JALR, LUI and AUIPC, and only when rd != 0. It is 0 whenever illegal=1.
- Register-use flags:
  - use_rs1 = 0 for LUI, AUIPC, JAL and SYSTEM.
  - use_rs2 = 1 only for RR, STORE and BRANCH.
- Illegal conditions:
  - Unknown opcode, or i[1:0] != 2'b11.
  - RR with funct7 not in {0x00,0x20}, or 0x20 with f3 not in {000,101}.
  - SLLI with funct7 != 0.
  - SRLI/SRAI with funct7 not in {0x00,0x20}.
  - LOAD with f3 in {011,110,111}.
  - STORE with f3 > 010.
  - BRANCH with f3 in {010,011}.
  - JALR with f3 != 0.
  - SYSTEM with anything other than exactly ECALL (0x00000073) or EBREAK (0x00100073).
- Illegal bundles still propagate with out_valid=1 and out_illegal=1, so the exception unit sees them.
- Boundary case: x0 as rd keeps decode normal with reg_we=0. The NOP 0x00000013 decodes as ALU_IMM ADD with reg_we=0.

Decomposition:
- Add alu_op_t and instr_class_t enums plus FENCE-free opcode constants to the riscv package, alongside the existing opcode localparams and funct3 enums.
- Sub-module decode_comb (purely combinational instr→bundle), reusable by a trace monitor. decode_stage wraps it with the handshake register.

Test Plan:
- addi x5,x0,-1 (0xFFF00293), out_ready=1 → next cycle out_valid=1, rd=5, rs1=0, imm=0xFFFFFFFF, alu=ADD, cls=ALU_IMM, reg_we=1.
- sub x3,x1,x2 (0x402081B3) → alu=SUB, rs1=1, rs2=2, rd=3, use_rs2=1. Then sw x2,-4(x1) (0xFE20AE23) → cls=STORE, imm=0xFFFFFFFC, f3=010, reg_we=0.
- beq x0,x0,-8 (0xFE000CE3) → cls=BRANCH, imm=0xFFFFFFF8, alu=SUB.
  - 0xFFFFFFFF → illegal=1, reg_we=0.
  - 0x00100073 → ebreak=1.
- Stream 3 instructions with out_ready low for 2 cycles → first bundle held stable, in_ready=0, no loss or duplication; order is preserved after out_ready returns.
- flush asserted with in_valid=1 and out_valid=1 → next cycle out_valid=0; the following accepted instruction emerges normally.
- rst_n asserted mid-stream asynchronously → out_valid drops immediately and all outputs are 0. After release, the first instruction decodes with 1-cycle latency.
